muldiv_iter_unit: RTL
=====================

// Module: muldiv_iter_unit
// PURPOSE
//   Parametrised iterative multiply/divide unit for the EX stage. It replaces the separate mul/div
//   instances and implements MULT, MULTU, DIV and DIVU on one shared shift/add datapath.
//   It produces {hi,lo} for the HI/LO write path and raises an EX stall request while it is busy.
//   It supports flush (annul) and has a fast path for divide-by-zero.
// PARAMETERS
//   DATA_W         32  operand width; results are 2*DATA_W bits
//   DIV_ZERO_FAST  1   1: divide-by-zero completes without iterating; 0: it takes the normal path
// PORTS
//   clk         in   1          rising-edge clock (single clock domain)
//   resetn      in   1          reset, asynchronous, active-low
//   start_i     in   1          request; EX holds it high until ready_o
//   annul_i     in   1          abort the current operation (pipeline flush)
//   op_i        in   2          [1] 1=divide, 0=multiply; [0] 1=signed, 0=unsigned
//   opdata1_i   in   DATA_W     multiplicand or dividend (rs)
//   opdata2_i   in   DATA_W     multiplier or divisor (rt)
//   busy_o      out  1          high in every state except IDLE
//   ready_o     out  1          one-cycle pulse: result_o is valid
//   result_o    out  2*DATA_W   {hi,lo}; mul={upper,lower}, div={remainder,quotient}
//   stallreq_o  out  1          start_i & ~ready_o & ~annul_i (combinational)
// BEHAVIOUR
//   - Reset: state=IDLE; busy_o=0, ready_o=0, result_o=0; counter and accumulator are 0.
//     Asserting reset mid-operation aborts immediately; no ready_o pulse is produced.
//   - States: IDLE -> CALC -> FIX -> DONE -> IDLE; also IDLE -> DONE for divide-by-zero when DIV_ZERO_FAST=1.
//   - IDLE: start_i=1 and annul_i=0 latches op_i, |opdata1_i| and |opdata2_i|.
//     Absolute values are taken only when op_i[0]=1; the operand signs are recorded.
//     Counter is loaded with DATA_W; next state is CALC.
//   - Operands are captured only in IDLE; changes to the inputs during CALC/FIX are ignored.
//   - CALC: one iteration per cycle; counter decrements; leaves to FIX when counter reaches 1.
//   - CALC multiply: shift-add on a (2*DATA_W+1)-bit accumulator.
//     If acc[0]=1, add the multiplicand to the upper half; then shift right by 1.
//   - CALC divide: restoring divide. Shift {rem,quo} left by 1, then trial-subtract the divisor
//     from rem. If the result is non-negative, commit it and set quo[0]=1.
//   - FIX (1 cycle): signed multiply negates the product if sign_a^sign_b.
//     Signed divide negates the quotient if sign_a^sign_b and the remainder if sign_a.
//     result_o is registered at the end of FIX.
//   - DONE (1 cycle): ready_o=1 and the next state is IDLE. start_i is ignored in DONE,
//     so a held start does not retrigger.
//   - result_o holds its value until the next DONE; it is never cleared by annul.
//   - Latency: start sampled at edge t0 gives ready_o high in cycle t0+DATA_W+2 (34 cycles at DATA_W=32).
//   - Divide-by-zero result: quotient = all ones; remainder = the dividend as given (sign unchanged).
//     DIV_ZERO_FAST=1: IDLE -> DONE directly, so ready_o is high in cycle t0+1.
//   - Signed overflow (most-negative / -1): quotient = most-negative value, remainder = 0, no trap.
//   - Annul: in CALC/FIX/DONE, next state is IDLE, ready_o is forced to 0 that cycle,
//     and result_o is not updated. In IDLE, annul_i=1 blocks a start in the same cycle.
//   - Arithmetic width: all intermediates are unsigned, DATA_W+1 bits for the trial subtract.
//     The most-negative absolute value is treated as the unsigned magnitude 2^(DATA_W-1).
// STRUCTURE
//   - Shared package muldiv_pkg:
//     - op encodings OP_MULTU=2'b00, OP_MULT=2'b01, OP_DIVU=2'b10, OP_DIV=2'b11;
//     - state encoding S_IDLE, S_CALC, S_FIX, S_DONE;
//     - counter width function clog2(DATA_W+1).
//   - One sub-module, muldiv_negate: parametrised conditional two's-complement (en ? -x : x).
//     It is instantiated for the input absolute values and for the FIX correction.
//   - FSM, counter and accumulator stay in the top module.
// TESTING
//   - MULT 0xFFFFFFFE * 0x00000003 -> ready_o at t0+34; result_o = 0xFFFFFFFF_FFFFFFFA.
//   - MULTU 0xFFFFFFFF * 0xFFFFFFFF -> result_o = 0xFFFFFFFE_00000001.
//   - DIV -7 / 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1).
//     DIVU 100 / 7 -> lo = 14, hi = 2.
//   - DIV 5 / 0 with DIV_ZERO_FAST=1 -> ready_o at t0+1, lo = 0xFFFFFFFF, hi = 5.
//     DIV 0x80000000 / -1 -> lo = 0x80000000, hi = 0.
//   - Assert annul_i at cycle t0+10 -> busy_o=0 at t0+11, no ready_o pulse, result_o keeps its old value.
//     A new start at t0+12 completes normally.
//   - Hold start_i through DONE -> exactly one ready_o pulse; stallreq_o drops in the ready cycle.
//     Drop resetn mid-CALC -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state encoding and a width helper for the iteration counter.
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Number of bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement: o_y = i_en ? -i_x : i_x.
// Used for operand magnitudes on entry and for the sign correction of results.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic         i_en,
  input  logic [W-1:0] i_x,
  output logic [W-1:0] o_y
);

  assign o_y = i_en ? (~i_x + W'(1)) : i_x;

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative multiply/divide unit for the EX stage. MULT/MULTU/DIV/DIVU share
// one (2*DATA_W+1)-bit accumulator: shift-add for multiply, restoring divide
// for divide. Magnitudes are processed unsigned and the sign is fixed up in
// a single FIX cycle. Result layout is {hi,lo}: mul={upper,lower},
// div={remainder,quotient}.
//
// Handshake: EX raises start_i and holds it (with stable operands) until it
// sees the one-cycle ready_o pulse; operands are captured only when the unit
// accepts the request in IDLE. stallreq_o stays high while a request is
// pending and not yet answered. annul_i aborts any operation in flight and
// blocks a same-cycle start.
module muldiv_iter_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter bit DIV_ZERO_FAST = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic                  busy_o,
  output logic                  ready_o,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  stallreq_o,
  output state_t                dbg_state_o
);

  localparam int CNT_W = clog2(DATA_W + 1);
  localparam int ACC_W = 2 * DATA_W + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [ACC_W-1:0]      r_acc;
  logic [DATA_W-1:0]     r_opnd;      // multiplicand (mul) or divisor (div) magnitude
  logic [1:0]            r_op;
  logic                  r_sign_a;
  logic                  r_sign_b;
  logic                  r_div_zero;
  logic [2*DATA_W-1:0]   r_result;

  logic                  w_sign_a;
  logic                  w_sign_b;
  logic [DATA_W-1:0]     w_abs_a;
  logic [DATA_W-1:0]     w_abs_b;
  logic                  w_start;
  logic                  w_fast_dz;
  logic [DATA_W:0]       w_mul_sum;
  logic [ACC_W-1:0]      w_mul_next;
  logic [DATA_W:0]       w_rem_sh;
  logic [DATA_W:0]       w_trial;
  logic [ACC_W-1:0]      w_div_next;
  logic                  w_neg_res;
  logic [2*DATA_W-1:0]   w_prod_fix;
  logic [DATA_W-1:0]     w_quo_fix;
  logic [DATA_W-1:0]     w_rem_fix;
  logic [2*DATA_W-1:0]   w_fix_result;

  // Operand signs only matter for the signed ops.
  assign w_sign_a  = op_i[0] & opdata1_i[DATA_W-1];
  assign w_sign_b  = op_i[0] & opdata2_i[DATA_W-1];
  assign w_start   = start_i & ~annul_i;
  assign w_fast_dz = DIV_ZERO_FAST & op_i[1] & (opdata2_i == '0);

  muldiv_negate #(.W(DATA_W)) u_abs_a (.i_en(w_sign_a), .i_x(opdata1_i), .o_y(w_abs_a));
  muldiv_negate #(.W(DATA_W)) u_abs_b (.i_en(w_sign_b), .i_x(opdata2_i), .o_y(w_abs_b));

  // Multiply step: add multiplicand into the upper half when the low bit is set, then shift right.
  assign w_mul_sum  = r_acc[ACC_W-1:DATA_W] + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {1'b0, w_mul_sum, r_acc[DATA_W-1:1]};

  // Divide step: shift {rem,quo} left and trial-subtract; bit DATA_W of the trial is the borrow.
  assign w_rem_sh   = r_acc[2*DATA_W-1:DATA_W-1];
  assign w_trial    = w_rem_sh - {1'b0, r_opnd};
  assign w_div_next = w_trial[DATA_W]
                    ? {1'b0, w_rem_sh[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0}
                    : {1'b0, w_trial[DATA_W-1:0],  r_acc[DATA_W-2:0], 1'b1};

  // Sign correction applied in FIX; the remainder follows the dividend sign.
  assign w_neg_res = r_op[0] & (r_sign_a ^ r_sign_b);

  muldiv_negate #(.W(2*DATA_W)) u_fix_prod (.i_en(w_neg_res), .i_x(r_acc[2*DATA_W-1:0]), .o_y(w_prod_fix));
  muldiv_negate #(.W(DATA_W))   u_fix_quo  (.i_en(w_neg_res), .i_x(r_acc[DATA_W-1:0]), .o_y(w_quo_fix));
  muldiv_negate #(.W(DATA_W))   u_fix_rem  (.i_en(r_op[0] & r_sign_a), .i_x(r_acc[2*DATA_W-1:DATA_W]), .o_y(w_rem_fix));

  // Divide-by-zero always reports an all-ones quotient, even on the iterating path.
  assign w_fix_result = r_op[1]
                      ? {w_rem_fix, (r_div_zero ? {DATA_W{1'b1}} : w_quo_fix)}
                      : w_prod_fix;

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state and status outputs; annul returns to IDLE and suppresses ready.
  always_comb begin
    w_next_state = r_state;
    busy_o       = (r_state != S_IDLE);
    ready_o      = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) w_next_state = w_fast_dz ? S_DONE : S_CALC;
      S_CALC: begin
        if (annul_i)               w_next_state = S_IDLE;
        else if (r_cnt == CNT_ONE) w_next_state = S_FIX;
      end
      S_FIX:  w_next_state = annul_i ? S_IDLE : S_DONE;
      S_DONE: begin
        w_next_state = S_IDLE;
        ready_o      = ~annul_i;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: capture in IDLE, iterate in CALC, register the corrected result in FIX.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_op       <= '0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_div_zero <= 1'b0;
      r_result   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_op       <= op_i;
            r_sign_a   <= w_sign_a;
            r_sign_b   <= w_sign_b;
            r_div_zero <= op_i[1] & (opdata2_i == '0);
            r_cnt      <= CNT_LOAD;
            if (op_i[1]) begin
              r_opnd <= w_abs_b;
              r_acc  <= {{(DATA_W+1){1'b0}}, w_abs_a};
            end else begin
              r_opnd <= w_abs_a;
              r_acc  <= {{(DATA_W+1){1'b0}}, w_abs_b};
            end
            if (w_fast_dz) r_result <= {opdata1_i, {DATA_W{1'b1}}};
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt - CNT_ONE;
          r_acc <= r_op[1] ? w_div_next : w_mul_next;
        end
        S_FIX: if (!annul_i) r_result <= w_fix_result;
        default: ;
      endcase
    end
  end

  assign result_o    = r_result;
  assign stallreq_o  = start_i & ~ready_o & ~annul_i;
  assign dbg_state_o = r_state;

endmodule
